// File: rtl/lane_judge.sv
// lane_judge: chart follower and hit judge for one rhythm-game lane.
// Walks the note chart ROM one head entry at a time, times key presses and
// releases against the song clock, and keeps this lane's combo and score.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | after reset; nothing is judged, addr parked at 0
// WAIT_NOTE | head is a tap, hold start or orphan end; wait for press/timeout
// HOLDING   | hold start was hit and the key is down; head is the hold end
// DONE      | chart exhausted; outputs frozen until start

module lane_judge #(
    parameter int CHART_LEN   = 126,
    parameter int PERFECT_WIN = 3,
    parameter int GOOD_WIN    = 7,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [13:0] song_time,
    input  logic        key_pressed,
    input  logic [15:0] key_1,
    input  logic [15:0] key_2,
    output logic [7:0]  addr,
    output logic        judge_valid,
    output logic [1:0]  judge_code,
    output logic        hold_active,
    output logic [9:0]  combo,
    output logic [15:0] score,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, WAIT_NOTE, HOLDING, DONE} state_t;

    localparam logic [1:0] TYPE_HOLD_START = 2'b01;
    localparam logic [1:0] TYPE_HOLD_END   = 2'b10;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_PERFECT = 2'b01;
    localparam logic [1:0] CODE_GOOD    = 2'b10;
    localparam logic [1:0] CODE_MISS    = 2'b11;

    localparam logic signed [14:0] PW_POS = 15'(PERFECT_WIN);
    localparam logic signed [14:0] PW_NEG = 15'(-PERFECT_WIN);
    localparam logic signed [14:0] GW_POS = 15'(GOOD_WIN);
    localparam logic signed [14:0] GW_NEG = 15'(-GOOD_WIN);

    localparam logic [8:0]  LEN9        = 9'(CHART_LEN);
    localparam logic [16:0] PERFECT_ADD = 17'(PERFECT_PTS);
    localparam logic [16:0] GOOD_ADD    = 17'(GOOD_PTS);

    state_t state;
    state_t state_nxt;

    logic              key_q;
    logic              press;
    logic              release_evt;
    logic signed [14:0] delta;
    logic [1:0]        head_type;
    logic              too_late;
    logic              too_early;
    logic              in_perfect;
    logic [1:0]        hit_code;
    logic              exhausted;

    logic [1:0]  ev;
    logic [7:0]  addr_nxt;
    logic        valid_nxt;
    logic [1:0]  code_nxt;
    logic        hold_nxt;
    logic [9:0]  combo_nxt;
    logic [15:0] score_nxt;
    logic [16:0] score_sum;
    logic        done_nxt;

    // The look-ahead entry is carried on the port for a future pre-fetch path only.
    logic unused_key_2;
    assign unused_key_2 = ^key_2;

    assign press       = key_pressed & ~key_q;
    assign release_evt = ~key_pressed & key_q;

    // Both operands are zero-extended, so the 15-bit difference is exact in two's complement.
    assign delta     = {1'b0, song_time} - {1'b0, key_1[13:0]};
    assign head_type = key_1[15:14];

    assign too_late   = delta > GW_POS;
    assign too_early  = delta < GW_NEG;
    assign in_perfect = (delta >= PW_NEG) && (delta <= PW_POS);
    assign hit_code   = in_perfect ? CODE_PERFECT : CODE_GOOD;
    assign exhausted  = {1'b0, addr} >= LEN9;

    // Next-state, judgment and scoring; start overrides everything decided above it
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        valid_nxt = 1'b0;
        code_nxt  = judge_code;
        hold_nxt  = hold_active;
        combo_nxt = combo;
        score_nxt = score;
        done_nxt  = done;
        score_sum = {1'b0, score};
        ev        = CODE_NONE;

        case (state)
            IDLE: begin
            end
            WAIT_NOTE: begin
                if (exhausted) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (head_type == TYPE_HOLD_END) begin
                    ev = CODE_MISS;
                end else if (too_late) begin
                    ev = CODE_MISS;
                end else if (press && !too_early) begin
                    ev = hit_code;
                    if (head_type == TYPE_HOLD_START) begin
                        state_nxt = HOLDING;
                        hold_nxt  = 1'b1;
                    end
                end
            end
            HOLDING: begin
                if (head_type != TYPE_HOLD_END) begin
                    state_nxt = WAIT_NOTE;
                    hold_nxt  = 1'b0;
                end else if (release_evt) begin
                    state_nxt = WAIT_NOTE;
                    hold_nxt  = 1'b0;
                    ev        = (too_early || too_late) ? CODE_MISS : hit_code;
                end else if (key_pressed && !delta[14]) begin
                    state_nxt = WAIT_NOTE;
                    hold_nxt  = 1'b0;
                    ev        = CODE_PERFECT;
                end
            end
            DONE: begin
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (ev != CODE_NONE) begin
            valid_nxt = 1'b1;
            code_nxt  = ev;
            addr_nxt  = addr + 8'd1;
            if (ev == CODE_MISS) begin
                combo_nxt = '0;
            end else begin
                combo_nxt = (combo == 10'h3FF) ? combo : combo + 10'd1;
                score_sum = {1'b0, score} + ((ev == CODE_PERFECT) ? PERFECT_ADD : GOOD_ADD);
                score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end
        end

        if (start) begin
            state_nxt = WAIT_NOTE;
            addr_nxt  = '0;
            valid_nxt = 1'b0;
            hold_nxt  = 1'b0;
            combo_nxt = '0;
            score_nxt = '0;
            done_nxt  = 1'b0;
        end
    end

    // State register, key history and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            key_q       <= 1'b0;
            addr        <= '0;
            judge_valid <= 1'b0;
            judge_code  <= '0;
            hold_active <= 1'b0;
            combo       <= '0;
            score       <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            key_q       <= key_pressed;
            addr        <= addr_nxt;
            judge_valid <= valid_nxt;
            judge_code  <= code_nxt;
            hold_active <= hold_nxt;
            combo       <= combo_nxt;
            score       <= score_nxt;
            done        <= done_nxt;
        end
    end

endmodule
